// File: rtl/dual_port_ram_reader_if.sv
// rtl/dual_port_ram_reader_if.sv - RAM read port and output stream bundle for dual_port_ram_reader
interface dual_port_ram_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              ram_port_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  // Reader side: drives the RAM read strobe/address and the stream beat.
  modport master (
    output ram_port_en,
    output ram_addr,
    output m_data,
    output m_valid,
    input  ram_data,
    input  m_ready
  );

  // RAM plus downstream consumer side.
  modport slave (
    input  ram_port_en,
    input  ram_addr,
    input  m_data,
    input  m_valid,
    output ram_data,
    output m_ready
  );
endinterface

// File: rtl/dual_port_ram_reader.sv
// rtl/dual_port_ram_reader.sv - port-1 read sweep engine with 2-entry skid buffer; optional DPR_READER_CHECKSUM_EN
module dual_port_ram_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  dual_port_ram_reader_if.master bus,
  output logic                  busy,
  output logic                  done
`ifdef DPR_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_L = 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic              rd_pending;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;

  logic              accept;
  logic              pop;
  logic              push;
  logic              issue;
  logic              all_done;
  logic [1:0]        occ;
  logic [1:0]        occ_after_pop;
  logic [2:0]        slots_used;

  // Buffer occupancy is counted net of the beat leaving this cycle, so a
  // full-rate stream can keep one read in flight while the head drains.
  assign accept        = (state == IDLE) && start;
  assign pop           = bus.m_valid && bus.m_ready;
  assign push          = rd_pending;
  assign occ           = {1'b0, bus.m_valid} + {1'b0, skid_valid};
  assign occ_after_pop = occ - {1'b0, pop};
  assign slots_used    = {1'b0, occ_after_pop} + {2'b00, rd_pending};
  assign issue         = (state == RUN) && (issued < len_q) && (slots_used < 3'd2);
  assign all_done      = (issued == len_q) && !rd_pending && (occ_after_pop == 2'd0);

  assign bus.ram_port_en = issue;
  assign bus.ram_addr    = cur;
  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: finish as soon as the last beat leaves, done lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (all_done) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address window bookkeeping: capture on start, advance on every issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      len_q  <= '0;
      issued <= '0;
    end else if (accept) begin
      cur    <= base_addr;
      len_q  <= length;
      issued <= '0;
    end else if (issue) begin
      cur    <= cur + ONE_A;
      issued <= issued + ONE_L;
    end
  end

  // RAM data appears one cycle after the strobe; track that read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= issue;
    end
  end

  // Two-entry skid buffer: head is the registered stream output, skid holds
  // the word that arrives while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      skid_data   <= '0;
      skid_valid  <= 1'b0;
    end else if (!bus.m_valid || pop) begin
      if (skid_valid) begin
        bus.m_data  <= skid_data;
        bus.m_valid <= 1'b1;
        skid_valid  <= push;
        if (push) begin
          skid_data <= bus.ram_data;
        end
      end else if (push) begin
        bus.m_data  <= bus.ram_data;
        bus.m_valid <= 1'b1;
      end else begin
        bus.m_valid <= 1'b0;
      end
    end else if (push) begin
      skid_data  <= bus.ram_data;
      skid_valid <= 1'b1;
    end
  end

`ifdef DPR_READER_CHECKSUM_EN
  // Running modular sum of transferred beats, cleared when a sweep starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + bus.m_data;
    end
  end
`else
`endif

endmodule

// File: tb/tb_dual_port_ram_reader.sv
// tb/tb_dual_port_ram_reader.sv - self-checking bench for dual_port_ram_reader
module tb_dual_port_ram_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] length = '0;
  logic       busy;
  logic       done;
`ifdef DPR_READER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  dual_port_ram_reader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  dual_port_ram_reader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
`ifdef DPR_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: preloaded mem[i] = i+1, registered read on port 1.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    bus.ram_data = '0;
  end
  always @(posedge clk) if (bus.ram_port_en) bus.ram_data <= mem[bus.ram_addr];

  // Downstream ready generator.
  int ready_mode = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    int idx = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.m_ready = 1'b1;
        1: begin bus.m_ready = pat[idx % 6]; idx++; end
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Scoreboards.
  int sb_addr [$];
  int sb_data [$];
  int n_beats = 0;
  int last_beat_cyc = -1;
  int first_valid_cyc = -1;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.ram_port_en) begin
        if (sb_addr.size() == 0) check("unexpected_read", 1, 0);
        else check("ram_addr", int'(bus.ram_addr), sb_addr.pop_front());
      end
      if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev && bus.m_valid) check("stall_hold", int'(bus.m_data), int'(stall_data));
      if (bus.m_valid && bus.m_ready) begin
        if (sb_data.size() == 0) check("unexpected_beat", 1, 0);
        else check("beat_data", int'(bus.m_data), sb_data.pop_front());
        n_beats++;
        last_beat_cyc = cyc;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end
  end

  task automatic push_expect(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % 16;
      sb_addr.push_back(a);
      sb_data.push_back(int'(mem[a]));
    end
  endtask

  task automatic pulse_start(input int base, input int len, output int start_cyc);
    @(posedge clk);
    #1;
    base_addr = 4'(base);
    length = 5'(len);
    start = 1'b1;
    start_cyc = cyc;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_read(input int base, input int len, input int mode, input int extra, input int exp_sum);
    int start_cyc;
    int done_cyc;
    bit got;
    ready_mode = mode;
    n_beats = 0;
    push_expect(base, len);
    pulse_start(base, len, start_cyc);
    got = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (extra != 0 && c == 4) begin
        base_addr = 4'd7;
        length = 5'd3;
        start = 1'b1;
      end
      if (c == 5) start = 1'b0;
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    if (len == 0) begin
      check("len0_done_latency", done_cyc - start_cyc, 2);
    end else begin
      check("first_valid_latency", first_valid_cyc - start_cyc, 3);
      check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
    end
    check("beat_count", n_beats, len);
    check("sb_data_empty", sb_data.size(), 0);
    check("sb_addr_empty", sb_addr.size(), 0);
`ifdef DPR_READER_CHECKSUM_EN
    check("checksum", int'(checksum), exp_sum);
`endif
    @(negedge clk);
    check("busy_after", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
  endtask

  typedef struct {
    int base;
    int len;
    int mode;
    int extra;
    int sum;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int sc;
    vecs[0] = '{base: 0,  len: 16, mode: 0, extra: 1, sum: 8'h88};
    vecs[1] = '{base: 14, len: 4,  mode: 0, extra: 0, sum: 8'h22};
    vecs[2] = '{base: 0,  len: 16, mode: 1, extra: 0, sum: 8'h88};
    vecs[3] = '{base: 5,  len: 1,  mode: 2, extra: 0, sum: 8'h06};
    vecs[4] = '{base: 15, len: 2,  mode: 1, extra: 0, sum: 8'h11};
    vecs[5] = '{base: 3,  len: 16, mode: 2, extra: 0, sum: 8'h88};

    // Reset state.
    #2;
    check("rst_ram_port_en", int'(bus.ram_port_en), 0);
    check("rst_ram_addr", int'(bus.ram_addr), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
`ifdef DPR_READER_CHECKSUM_EN
    check("rst_checksum", int'(checksum), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_read(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].extra, vecs[v].sum);

    // Zero-length request: no reads, no beats.
    ready_mode = 0;
    pulse_start(2, 0, sc);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("len0_no_valid", int'(bus.m_valid), 0);
      check("len0_no_read", int'(bus.ram_port_en), 0);
      if (cyc - sc == 2) check("len0_done_at_2", int'(done), 1);
      else check("len0_done_not_yet", int'(done), 0);
`ifdef DPR_READER_CHECKSUM_EN
      if (done) check("len0_checksum", int'(checksum), 0);
`endif
    end

    // Reset in the middle of a sweep, then a fresh short sweep.
    ready_mode = 0;
    n_beats = 0;
    push_expect(0, 16);
    pulse_start(0, 16, sc);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (n_beats >= 5) break;
    end
    check("mid_beats_reached", int'(n_beats >= 5), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_port_en", int'(bus.ram_port_en), 0);
    check("mid_rst_ram_addr", int'(bus.ram_addr), 0);
    check("mid_rst_m_data", int'(bus.m_data), 0);
    check("mid_rst_m_valid", int'(bus.m_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
`ifdef DPR_READER_CHECKSUM_EN
    check("mid_rst_checksum", int'(checksum), 0);
`endif
    sb_addr.delete();
    sb_data.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_read(3, 2, 0, 0, 8'h09);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
